// File: rtl/diff_channel_scheduler.sv
// Shares one third-order differentiator across NCH channels: each lr_clk rise snapshots
// all samples, then walks channels through S0/S1/S2 using per-channel history.
//
//  state | meaning
//  IDLE  | waiting for an lr_clk rising edge
//  S0    | d1 = x - h1[ch]
//  S1    | d2 = d1 - h2[ch]
//  S2    | d3 = d2 - h3[ch] to output, history of ch updated
module diff_channel_scheduler #(
   parameter int NCH     = 16,
   parameter int W       = 19,
   parameter int CH_BITS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 lr_clk,
   input  logic [W*NCH-1:0]     sample_in,
   input  logic                 clr_overrun,
   output logic [W-1:0]         out_data,
   output logic [CH_BITS-1:0]   out_ch,
   output logic                 out_valid,
   output logic                 out_last,
   output logic                 busy,
   output logic                 overrun
);

   typedef enum logic [1:0] {IDLE, S0, S1, S2} state_t;

   state_t               r_state;
   state_t               w_next_state;
   logic                 r_lr_prev;
   logic [CH_BITS-1:0]   r_ch;
   logic                 r_busy;
   logic                 r_overrun;
   logic                 r_out_valid;
   logic                 r_out_last;
   logic [W-1:0]         r_out_data;
   logic [CH_BITS-1:0]   r_out_ch;
   logic [W-1:0]         r_d1;
   logic [W-1:0]         r_d2;
   logic [W-1:0]         r_snap [NCH];
   logic [W-1:0]         r_h1   [NCH];
   logic [W-1:0]         r_h2   [NCH];
   logic [W-1:0]         r_h3   [NCH];

   logic                 w_edge;
   logic                 w_start;
   logic                 w_ovr_evt;
   logic                 w_last_ch;
   logic [W-1:0]         w_x;

   // The cycle after the final S2 (last result on the bus) still counts as busy.
   assign w_edge    = lr_clk & ~r_lr_prev;
   assign w_start   = w_edge & (r_state == IDLE) & ~r_out_last;
   assign w_ovr_evt = w_edge & ~w_start;
   assign w_last_ch = (r_ch == CH_BITS'(NCH - 1));
   assign w_x       = r_snap[r_ch];

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_start) w_next_state = S0;
         S0:      w_next_state = S1;
         S1:      w_next_state = S2;
         S2:      w_next_state = w_last_ch ? IDLE : S0;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_lr_prev   <= 1'b0;
         r_ch        <= '0;
         r_busy      <= 1'b0;
         r_overrun   <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_lr_prev   <= lr_clk;
         r_busy      <= (w_next_state != IDLE);
         r_out_valid <= (r_state == S2);
         r_out_last  <= (r_state == S2) && w_last_ch;
         if (w_start)
            r_ch <= '0;
         else if (r_state == S2 && !w_last_ch)
            r_ch <= r_ch + CH_BITS'(1);
         if (w_ovr_evt)
            r_overrun <= 1'b1;
         else if (clr_overrun)
            r_overrun <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_d1       <= '0;
         r_d2       <= '0;
         r_out_data <= '0;
         r_out_ch   <= '0;
         for (int k = 0; k < NCH; k++) begin
            r_snap[k] <= '0;
            r_h1[k]   <= '0;
            r_h2[k]   <= '0;
            r_h3[k]   <= '0;
         end
      end else begin
         if (w_start) begin
            for (int k = 0; k < NCH; k++)
               r_snap[k] <= sample_in[k*W +: W];
         end
         case (r_state)
            S0: r_d1 <= w_x - r_h1[r_ch];
            S1: r_d2 <= r_d1 - r_h2[r_ch];
            S2: begin
               r_out_data <= r_d2 - r_h3[r_ch];
               r_out_ch   <= r_ch;
               r_h1[r_ch] <= w_x;
               r_h2[r_ch] <= r_d1;
               r_h3[r_ch] <= r_d2;
            end
            default: ;
         endcase
      end
   end

   assign out_data  = r_out_data;
   assign out_ch    = r_out_ch;
   assign out_valid = r_out_valid;
   assign out_last  = r_out_last;
   assign busy      = r_busy;
   assign overrun   = r_overrun;

endmodule
